// File: rtl/mc_datapath_gen.sv
// Parametrised multicycle ARM-subset datapath with a MemReady stall input.
// Define MC_DP_MUL_EN to build the iterative shift-add multiplier and the MulHi register.
module mc_datapath_gen #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    input  logic             MemReady,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [3:0]       ALUControl,
    input  logic             MulStart,
    output logic             MulBusy,
    output logic             MulDone
);
    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [WIDTH-1:0] pc_q, data_q, a_q, wd_q, alu_out_q, alu_out_d;
    logic [31:0]      instr_q;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rd1, rd2, src_a, src_b, src_b_eff, ext_imm, alu_result, result, mul_hi;
    logic [WIDTH:0]   sum_full;
    logic [AW-1:0]    ra1, ra2, wa;
    logic             sub_op, logic_op;

    assign ra1 = RegSrc[0] ? PC_IDX : AW'(instr_q[19:16]);
    assign ra2 = RegSrc[1] ? AW'(instr_q[15:12]) : AW'(instr_q[3:0]);
    assign wa  = AW'(instr_q[15:12]);
    // The PC alias reads Result so that decode sees PC+8 without a real register.
    assign rd1 = (ra1 == PC_IDX) ? result : rf_q[ra1];
    assign rd2 = (ra2 == PC_IDX) ? result : rf_q[ra2];

    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr_q[11:0]};
            2'b10:   ext_imm = {{(WIDTH-26){instr_q[23]}}, instr_q[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (ALUSrcB)
            2'b00:   src_b = wd_q;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = WIDTH'(4);
            default: src_b = '0;
        endcase
    end
    assign src_a = ALUSrcA ? pc_q : a_q;

    // Subtraction is A + ~B + 1 so the adder carry-out is directly NOT borrow.
    assign sub_op    = (ALUControl == 4'b0001);
    assign logic_op  = (ALUControl >= 4'b0010) && (ALUControl <= 4'b0101);
    assign src_b_eff = sub_op ? ~src_b : src_b;
    assign sum_full  = {1'b0, src_a} + {1'b0, src_b_eff} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        alu_result = sum_full[WIDTH-1:0];
        case (ALUControl)
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = src_b;
            default: alu_result = sum_full[WIDTH-1:0];
        endcase
    end

    assign ALUFlags[3] = alu_result[WIDTH-1];
    assign ALUFlags[2] = (alu_result == '0);
    assign ALUFlags[1] = logic_op ? 1'b0 : sum_full[WIDTH];
    assign ALUFlags[0] = logic_op ? 1'b0 :
                         (src_a[WIDTH-1] == src_b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        result = alu_out_q;
        case (ResultSrc)
            2'b00:   result = alu_out_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = mul_hi;
        endcase
    end

    assign Adr       = AdrSrc ? result : pc_q;
    assign WriteData = wd_q;
    assign Instr     = instr_q;

`ifdef MC_DP_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mul_mcand_q, mul_acc_q, mul_sum;
    logic [WIDTH-1:0]   mul_mplier_q, mul_hi_q;
    logic [CW-1:0]      mul_cnt_q;
    logic               mul_busy_q, mul_done_q, mul_last;

    assign mul_sum  = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
    assign mul_last = mul_busy_q && MemReady && (mul_cnt_q == CW'(1));
    assign mul_hi   = mul_hi_q;
    assign MulBusy  = mul_busy_q;
    assign MulDone  = mul_done_q;
    assign alu_out_d = mul_last   ? mul_sum[WIDTH-1:0] :
                       mul_busy_q ? alu_out_q : alu_result;

    // A start is accepted only when neither iterating nor presenting the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_mcand_q  <= '0;
            mul_acc_q    <= '0;
            mul_mplier_q <= '0;
            mul_hi_q     <= '0;
            mul_cnt_q    <= '0;
            mul_busy_q   <= 1'b0;
            mul_done_q   <= 1'b0;
        end else begin
            mul_done_q <= mul_last;
            if (MemReady) begin
                if (mul_busy_q) begin
                    mul_acc_q    <= mul_sum;
                    mul_mcand_q  <= mul_mcand_q << 1;
                    mul_mplier_q <= mul_mplier_q >> 1;
                    mul_cnt_q    <= mul_cnt_q - CW'(1);
                    if (mul_last) begin
                        mul_busy_q <= 1'b0;
                        mul_hi_q   <= mul_sum[2*WIDTH-1:WIDTH];
                    end
                end else if (MulStart && !mul_done_q) begin
                    mul_mcand_q  <= {{WIDTH{1'b0}}, src_a};
                    mul_mplier_q <= src_b;
                    mul_acc_q    <= '0;
                    mul_cnt_q    <= CW'(WIDTH);
                    mul_busy_q   <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_mul_start;

    assign unused_mul_start = MulStart;
    assign mul_hi    = '0;
    assign MulBusy   = 1'b0;
    assign MulDone   = 1'b0;
    assign alu_out_d = alu_result;
`endif

    always_ff @(posedge clk) begin
        if (RegWrite && MemReady && (wa != PC_IDX)) rf_q[wa] <= result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            a_q       <= '0;
            wd_q      <= '0;
            alu_out_q <= '0;
        end else if (MemReady) begin
            data_q    <= ReadData;
            a_q       <= rd1;
            wd_q      <= rd2;
            alu_out_q <= alu_out_d;
            if (PCWrite) pc_q <= result;
            if (IRWrite) instr_q <= ReadData[31:0];
        end
    end
endmodule

// File: tb/tb_mc_datapath_gen.sv
// Directed bench for mc_datapath_gen; multiplier scenarios build when MC_DP_MUL_EN is defined.
module tb_mc_datapath_gen;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  Adr, WriteData, ReadData;
    logic          MemReady;
    logic [31:0]   Instr;
    logic [3:0]    ALUFlags;
    logic          PCWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, MulStart, MulBusy, MulDone;
    logic [1:0]    RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]    ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    mc_datapath_gen #(.WIDTH(W), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [1:0]  bsel;
        logic [1:0]  imm;
        logic [31:0] res;
        logic [3:0]  flg;
    } alu_vec_t;

    // SrcA = PC = 0x7FFFFFFF, Instr = 0xE3A00F01
    localparam alu_vec_t ALU_VECS [14] = '{
        '{4'h0, 2'd1, 2'd0, 32'h80000000, 4'b1001},
        '{4'h1, 2'd1, 2'd0, 32'h7FFFFFFE, 4'b0010},
        '{4'h2, 2'd1, 2'd0, 32'h00000001, 4'b0000},
        '{4'h3, 2'd1, 2'd0, 32'h7FFFFFFF, 4'b0000},
        '{4'h4, 2'd1, 2'd0, 32'h7FFFFFFE, 4'b0000},
        '{4'h5, 2'd1, 2'd0, 32'h00000001, 4'b0000},
        '{4'hF, 2'd1, 2'd0, 32'h80000000, 4'b1001},
        '{4'h2, 2'd3, 2'd0, 32'h00000000, 4'b0100},
        '{4'h1, 2'd3, 2'd0, 32'h7FFFFFFF, 4'b0010},
        '{4'h5, 2'd1, 2'd1, 32'h00000F01, 4'b0000},
        '{4'h5, 2'd1, 2'd2, 32'hFE803C04, 4'b1000},
        '{4'h5, 2'd1, 2'd3, 32'h00000000, 4'b0100},
        '{4'h5, 2'd2, 2'd0, 32'h00000004, 4'b0000},
        '{4'h0, 2'd1, 2'd2, 32'h7E803C03, 4'b0010}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; RegSrc = 2'b00;
        ALUSrcA = 0; ALUSrcB = 2'd0; ResultSrc = 2'd0; ImmSrc = 2'd0;
        ALUControl = 4'h0; MulStart = 0; MemReady = 1;
    endtask

    task automatic test_reset();
        reset = 1; ReadData = '0; idle_ctrl();
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %h exp 0", Adr); end
        n_checks++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", Instr); end
        n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_wd got %h exp 0", WriteData); end
        n_checks++; if (ALUFlags !== 4'b0100) begin n_fail++; $display("FAIL reset_flags got %b exp 0100", ALUFlags); end
        n_checks++; if ({MulBusy, MulDone} !== 2'b00) begin n_fail++; $display("FAIL reset_mul got %b exp 00", {MulBusy, MulDone}); end
        reset = 0;
    endtask

    task automatic test_fetch();
        idle_ctrl();
        IRWrite = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'd2; ResultSrc = 2'd2;
        ReadData = 32'hE0812003;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL fetch_adr0 got %h exp 0", Adr); end
        tick();
        n_checks++; if (Instr !== 32'hE0812003) begin n_fail++; $display("FAIL fetch_instr got %h exp E0812003", Instr); end
        n_checks++; if (Adr !== 32'h4) begin n_fail++; $display("FAIL fetch_pc4 got %h exp 4", Adr); end
        tick();
        n_checks++; if (Adr !== 32'h8) begin n_fail++; $display("FAIL fetch_pc8 got %h exp 8", Adr); end
    endtask

    task automatic test_stall();
        MemReady = 0; ReadData = 32'hE1A00000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (Adr !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 8", i, Adr); end
            n_checks++; if (Instr !== 32'hE0812003) begin n_fail++; $display("FAIL stall_instr[%0d] got %h exp E0812003", i, Instr); end
        end
        MemReady = 1;
        tick();
        n_checks++; if (Adr !== 32'hC) begin n_fail++; $display("FAIL stall_pc_resume got %h exp C", Adr); end
        n_checks++; if (Instr !== 32'hE1A00000) begin n_fail++; $display("FAIL stall_instr_resume got %h exp E1A00000", Instr); end
    endtask

    task automatic test_reset_mid();
        idle_ctrl();
        reset = 1;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc got %h exp 0", Adr); end
        n_checks++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr got %h exp 0", Instr); end
        n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL rstmid_wd got %h exp 0", WriteData); end
        n_checks++; if (MulBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", MulBusy); end
        AdrSrc = 1;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL rstmid_aluout got %h exp 0", Adr); end
        reset = 0;
    endtask

    task automatic test_alu();
        idle_ctrl();
        IRWrite = 1; ReadData = 32'hE3A00F01;
        tick();
        IRWrite = 0; ReadData = 32'h7FFFFFFF;
        tick();
        ResultSrc = 2'd1; PCWrite = 1;
        tick();
        n_checks++; if (Adr !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL alu_pc_load got %h exp 7FFFFFFF", Adr); end
        PCWrite = 0; ALUSrcA = 1; ResultSrc = 2'd2; AdrSrc = 1;
        for (int i = 0; i < 14; i++) begin
            ALUControl = ALU_VECS[i].ctl; ALUSrcB = ALU_VECS[i].bsel; ImmSrc = ALU_VECS[i].imm;
            #1;
            n_checks++;
            if (Adr !== ALU_VECS[i].res) begin
                n_fail++; $display("FAIL alu_res[%0d] got %h exp %h", i, Adr, ALU_VECS[i].res);
            end
            n_checks++;
            if (ALUFlags !== ALU_VECS[i].flg) begin
                n_fail++; $display("FAIL alu_flags[%0d] got %b exp %b", i, ALUFlags, ALU_VECS[i].flg);
            end
        end
    endtask

    task automatic test_regfile();
        idle_ctrl();
        IRWrite = 1; ReadData = 32'hE0812003;
        tick();
        IRWrite = 0; ReadData = 32'h12345678;
        tick();
        ResultSrc = 2'd1; RegWrite = 1;
        tick();
        RegWrite = 0; RegSrc = 2'b11;
        tick();
        n_checks++; if (WriteData !== 32'h12345678) begin n_fail++; $display("FAIL rf_read_r2 got %h exp 12345678", WriteData); end
        ResultSrc = 2'd2; ALUSrcA = 0; ALUSrcB = 2'd3; AdrSrc = 1;
        #1;
        n_checks++; if (Adr !== 32'h12345678) begin n_fail++; $display("FAIL rf_pc_alias got %h exp 12345678", Adr); end
        MemReady = 0; RegWrite = 1; ALUSrcA = 1;
        tick();
        MemReady = 1; RegWrite = 0;
        tick();
        n_checks++; if (WriteData !== 32'h12345678) begin n_fail++; $display("FAIL rf_stall_gate got %h exp 12345678", WriteData); end
        ResultSrc = 2'd0;
        #1;
        n_checks++; if (Adr !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL aluout_load got %h exp 7FFFFFFF", Adr); end
    endtask

`ifdef MC_DP_MUL_EN
    task automatic test_mul_max();
        int n;
        idle_ctrl();
        IRWrite = 1; ReadData = 32'hE000F00F;
        tick();
        IRWrite = 0; ReadData = 32'hFFFFFFFF;
        tick();
        ResultSrc = 2'd1; PCWrite = 1;
        tick();
        PCWrite = 0; ALUSrcA = 1; ALUSrcB = 2'd0; MulStart = 1;
        tick();
        MulStart = 0; ALUControl = 4'h5; ResultSrc = 2'd0; AdrSrc = 1;
        n_checks++; if (MulBusy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_rise got %b exp 1", MulBusy); end
        n_checks++; if (Adr !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_aluout_hold got %h exp FFFFFFFE", Adr); end
        n = 0;
        while (MulDone !== 1'b1 && n < 60) begin
            MulStart = (n == 10);
            tick();
            n++;
        end
        MulStart = 0;
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL mul_latency got %0d exp 32", n); end
        n_checks++; if (MulBusy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_fall got %b exp 0", MulBusy); end
        n_checks++; if (Adr !== 32'h00000001) begin n_fail++; $display("FAIL mul_lo got %h exp 1", Adr); end
        ResultSrc = 2'd3;
        #1;
        n_checks++; if (Adr !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mul_hi got %h exp FFFFFFFE", Adr); end
        MulStart = 1;
        tick();
        MulStart = 0;
        n_checks++; if ({MulBusy, MulDone} !== 2'b00) begin n_fail++; $display("FAIL mul_start_on_done got %b exp 00", {MulBusy, MulDone}); end
    endtask

    task automatic test_mul_abort();
        int n;
        bit seen_done;
        idle_ctrl();
        ReadData = 32'hFFFFFFFF; ResultSrc = 2'd1; ALUSrcA = 1;
        tick();
        MulStart = 1;
        tick();
        MulStart = 0; ResultSrc = 2'd0; AdrSrc = 1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (MulDone === 1'b1) seen_done = 1;
        end
        n_checks++; if (MulBusy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b exp 1", MulBusy); end
        reset = 1;
        #1;
        n_checks++; if ({MulBusy, MulDone} !== 2'b00) begin n_fail++; $display("FAIL abort_mul got %b exp 00", {MulBusy, MulDone}); end
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL abort_aluout got %h exp 0", Adr); end
        ResultSrc = 2'd3;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL abort_mulhi got %h exp 0", Adr); end
        reset = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MulDone === 1'b1) seen_done = 1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b exp 0", seen_done); end

        idle_ctrl();
        IRWrite = 1; ReadData = 32'hE3A00005;
        tick();
        IRWrite = 0; ReadData = 32'h3;
        tick();
        ResultSrc = 2'd1; PCWrite = 1;
        tick();
        PCWrite = 0; ALUSrcA = 1; ALUSrcB = 2'd1; MulStart = 1;
        tick();
        MulStart = 0; ResultSrc = 2'd0; AdrSrc = 1;
        n = 0;
        while (MulDone !== 1'b1 && n < 60) begin
            MemReady = !(n == 5 || n == 6);
            tick();
            n++;
        end
        MemReady = 1;
        n_checks++; if (n !== 34) begin n_fail++; $display("FAIL mul3x5_latency got %0d exp 34", n); end
        n_checks++; if (Adr !== 32'd15) begin n_fail++; $display("FAIL mul3x5_lo got %h exp F", Adr); end
        ResultSrc = 2'd3;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL mul3x5_hi got %h exp 0", Adr); end
    endtask
`else
    task automatic test_no_mul();
        idle_ctrl();
        ALUSrcA = 1; ALUSrcB = 2'd2; MulStart = 1;
        tick();
        tick();
        MulStart = 0;
        n_checks++; if ({MulBusy, MulDone} !== 2'b00) begin n_fail++; $display("FAIL nomul_flags got %b exp 00", {MulBusy, MulDone}); end
        AdrSrc = 1; ResultSrc = 2'd3;
        #1;
        n_checks++; if (Adr !== 32'h0) begin n_fail++; $display("FAIL nomul_mulhi got %h exp 0", Adr); end
        ResultSrc = 2'd0;
        #1;
        n_checks++; if (Adr !== 32'h80000003) begin n_fail++; $display("FAIL nomul_aluout got %h exp 80000003", Adr); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_reset_mid();
        test_alu();
        test_regfile();
`ifdef MC_DP_MUL_EN
        test_mul_max();
        test_mul_abort();
`else
        test_no_mul();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
